// File: rtl/b09_pkg.sv
// Shared types and constants for the b09 serial frame receiver.
// Holds the deserializer state encoding and the frame layout constants.
package b09_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int   FRAME_W   = 8;
    localparam logic START_BIT = 1'b1;

endpackage

// File: rtl/b09_sync_fifo.sv
// Synchronous FIFO, DEPTH entries (power of two), storage reset to zero.
// Latency: write visible on rd_dat the cycle after push; pop advances immediately.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module b09_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_dat
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign rd_dat = mem_q[rd_ptr_q];

    // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/b09_frame_rx.sv
// Serial frame receiver: start bit 1 + 8 data bits LSB first into a small FIFO.
// Latency: rx_valid rises 2 clocks after the last data bit when the FIFO is empty.
// Backpressure: rx_valid/rx_ready pop; frames completing into a full FIFO are dropped
// and set sticky overflow. Optional duplicate filter: B09_FRAME_RX_DUP_FILTER_EN.
module b09_frame_rx
    import b09_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               y_in,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic               overflow,
    output logic               busy
);

    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic               push_q, push_d;
    logic [FRAME_W-1:0] push_dat_q, push_dat_d;
    logic [FRAME_W-1:0] prev_byte_q, prev_byte_d;
    logic               have_prev_q, have_prev_d;
    logic [IW-1:0]      idle_cnt_q, idle_cnt_d;
    logic               overflow_q, overflow_d;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               keep_byte;

    assign rx_valid = !fifo_empty;
    assign pop      = rx_valid && rx_ready;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE);

`ifdef B09_FRAME_RX_DUP_FILTER_EN
    assign keep_byte = !(have_prev_q && (shreg_q == prev_byte_q));
`else
    logic unused_hist;
    assign keep_byte   = 1'b1;
    assign unused_hist = ^{prev_byte_q, have_prev_q};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        push_d      = 1'b0;
        push_dat_d  = push_dat_q;
        prev_byte_d = prev_byte_q;
        have_prev_d = have_prev_q;
        idle_cnt_d  = idle_cnt_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (y_in == START_BIT) begin
                    state_d    = SHIFT;
                    cnt_d      = '0;
                    idle_cnt_d = '0;
                end else begin
                    if (idle_cnt_q != IW'(IDLE_TIMEOUT)) begin
                        idle_cnt_d = idle_cnt_q + IW'(1);
                    end
                    if (idle_cnt_d == IW'(IDLE_TIMEOUT)) begin
                        have_prev_d = 1'b0;
                    end
                end
            end
            SHIFT: begin
                shreg_d[cnt_q] = y_in;
                cnt_d          = cnt_q + 3'd1;
                idle_cnt_d     = '0;
                if (cnt_q == 3'd7) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // The push is staged one cycle so the FIFO write lands 2 clocks after the last bit.
                push_d      = keep_byte;
                push_dat_d  = shreg_q;
                prev_byte_d = shreg_q;
                have_prev_d = 1'b1;
                cnt_d       = '0;
                if (y_in == START_BIT) begin
                    state_d    = SHIFT;
                    idle_cnt_d = '0;
                end else begin
                    // This zero is already the first idle bit of the gap.
                    state_d    = IDLE;
                    idle_cnt_d = IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (push_q && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            push_q      <= 1'b0;
            push_dat_q  <= '0;
            prev_byte_q <= '0;
            have_prev_q <= 1'b0;
            idle_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            push_q      <= push_d;
            push_dat_q  <= push_dat_d;
            prev_byte_q <= prev_byte_d;
            have_prev_q <= have_prev_d;
            idle_cnt_q  <= idle_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    b09_sync_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clock),
        .reset    (reset),
        .push     (push_q),
        .push_dat (push_dat_q),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .rd_dat   (rx_data)
    );

endmodule

// File: tb/tb_b09_frame_rx.sv
// Bench for b09_frame_rx: directed scenarios then random frames, checked every cycle
// against a frame-level reference model (byte queue, scheduled pushes, idle-gap history).
module tb_b09_frame_rx;

    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       y_in;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overflow;
    logic       busy;

    always #5 clock = ~clock;

    b09_frame_rx #(
        .FIFO_DEPTH   (DEPTH),
        .IDLE_TIMEOUT (TIMEOUT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .y_in     (y_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .overflow (overflow),
        .busy     (busy)
    );

    typedef struct {
        int         e;
        logic [7:0] b;
    } pend_t;

    logic [7:0] q[$];
    pend_t      pend[$];
    bit         m_ovf;
    bit         inframe;
    bit         just_done;
    int         bidx;
    logic [7:0] sh;
    logic [7:0] prev;
    bit         have_prev;
    int         zcnt;
    int         edge_n;
    int         total;
    int         bad;
    int         delivered;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pend.delete();
        m_ovf     = 0;
        inframe   = 0;
        just_done = 0;
        bidx      = 0;
        sh        = '0;
        prev      = '0;
        have_prev = 0;
        zcnt      = 0;
    endtask

    // One clock: check outputs against the model, drive inputs, advance the model to the next edge.
    task automatic step(input logic y, input logic rdy, input logic rst);
        int  e;
        bit  pop;
        bit  dup;
        chk("rx_valid", {31'd0, rx_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0) chk("rx_data", {24'd0, rx_data}, {24'd0, q[0]});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("busy", {31'd0, busy}, {31'd0, inframe || just_done});
        y_in     = y;
        rx_ready = rdy;
        reset    = rst;
        e        = edge_n + 1;
        if (rst) begin
            model_reset();
        end else begin
            pop = (q.size() > 0) && rdy;
            if (pop) begin
                void'(q.pop_front());
                delivered++;
            end
            if (pend.size() > 0 && pend[0].e == e) begin
                if (q.size() < DEPTH) q.push_back(pend[0].b);
                else m_ovf = 1;
                void'(pend.pop_front());
            end
            just_done = 0;
            if (inframe) begin
                sh[bidx] = y;
                bidx++;
                if (bidx == 8) begin
                    inframe   = 0;
                    just_done = 1;
                    zcnt      = 0;
`ifdef B09_FRAME_RX_DUP_FILTER_EN
                    dup = have_prev && (sh == prev);
`else
                    dup = 0;
`endif
                    prev      = sh;
                    have_prev = 1;
                    if (!dup) pend.push_back('{e + 2, sh});
                end
            end else if (y) begin
                inframe = 1;
                bidx    = 0;
                zcnt    = 0;
            end else begin
                zcnt++;
                if (zcnt >= TIMEOUT) have_prev = 0;
            end
        end
        @(posedge clock);
        #1;
        edge_n = e;
    endtask

    function automatic logic rsel(input int mode);
        if (mode == 2) return logic'($urandom_range(0, 1));
        return (mode == 1);
    endfunction

    task automatic send_frame(input logic [7:0] b, input int mode);
        step(1'b1, rsel(mode), 1'b0);
        for (int i = 0; i < 8; i++) step(b[i], rsel(mode), 1'b0);
    endtask

    task automatic idle(input int n, input int mode);
        for (int i = 0; i < n; i++) step(1'b0, rsel(mode), 1'b0);
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] last_b;
        total     = 0;
        bad       = 0;
        delivered = 0;
        edge_n    = 0;
        model_reset();
        y_in      = 1'b0;
        rx_ready  = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        idle(3, 1);

        // Single frame 0xA5
        send_frame(8'hA5, 1);
        idle(5, 1);
        chk("single_delivered", delivered, 32'd1);

        // Back-to-back into a stalled FIFO
        send_frame(8'h01, 0);
        send_frame(8'h80, 0);
        send_frame(8'hFF, 0);
        idle(4, 0);
        chk("b2b_overflow", {31'd0, overflow}, 32'd1);
        idle(4, 1);
        chk("b2b_delivered", delivered, 32'd3);

        step(1'b0, 1'b0, 1'b1);
        idle(2, 1);
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Full FIFO with a pop on the exact push edge
        send_frame(8'h11, 0);
        send_frame(8'h22, 0);
        idle(4, 0);
        send_frame(8'h33, 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(6, 1);
        chk("simul_no_ovf", {31'd0, overflow}, 32'd0);

        // Duplicate sequence, then a repeat across an idle timeout
        send_frame(8'h3C, 1);
        send_frame(8'h3C, 1);
        send_frame(8'h3D, 1);
        idle(20, 1);
        send_frame(8'h3C, 1);
        idle(TIMEOUT, 1);
        send_frame(8'h3C, 1);
        idle(6, 1);

        // Reset mid-frame
        a5 = 8'hA5;
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(a5[i], 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        idle(2, 1);
        send_frame(8'h5A, 1);
        idle(5, 1);
        chk("midreset_ovf", {31'd0, overflow}, 32'd0);
        chk("midreset_empty", {31'd0, rx_valid}, 32'd0);

        // Random traffic
        step(1'b0, 1'b0, 1'b1);
        last_b = 8'h00;
        for (int f = 0; f < 300; f++) begin
            logic [7:0] b;
            int         gap;
            b = ($urandom_range(0, 3) == 0) ? last_b : 8'($urandom);
            send_frame(b, 2);
            last_b = b;
            case ($urandom_range(0, 5))
                0, 1:    gap = 0;
                2:       gap = 1;
                3:       gap = $urandom_range(2, 5);
                4:       gap = TIMEOUT - 1 + $urandom_range(0, 2);
                default: gap = $urandom_range(0, 3);
            endcase
            idle(gap, 2);
            if (f % 100 == 99) step(1'b0, 1'b0, 1'b1);
        end
        idle(10, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/b09_frame_rx.md
B09_FRAME_RX -- requirements
Module: b09_frame_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, number of buffered bytes (power of two, 2..8).
REQ-002 Parameter IDLE_TIMEOUT, default 16, consecutive zero bits that clear the previous-byte history.
REQ-003 clock  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 y_in  input  1  serial stream from the b09 converter stage, one bit per clock.
REQ-006 rx_data  output  8  head-of-FIFO byte.
REQ-007 rx_valid  output  1  FIFO non-empty.
REQ-008 rx_ready  input  1  consumer accepts rx_data when rx_valid and rx_ready are both high.
REQ-009 overflow  output  1  sticky; a completed frame was dropped because the FIFO was full.
REQ-010 busy  output  1  high when the deserializer FSM is not in IDLE.

Function
REQ-011 Frame format SHALL be: start bit 1, then 8 data bits LSB first, one bit per clock, with no gap required between frames.
REQ-012 FSM SHALL have exactly three states:
- IDLE: y_in=1 goes to SHIFT with bit count 0.
- SHIFT: shifts y_in into bit[count] and increments count; after the 8th bit goes to COMMIT.
- COMMIT: pushes the byte; y_in=1 goes to SHIFT (back-to-back frame), otherwise goes to IDLE.
REQ-013 Latency SHALL be fixed: rx_valid rises 2 clocks after the last data bit is sampled, when the FIFO was empty.
REQ-014 FIFO SHALL be first-in first-out with FIFO_DEPTH entries; pointers wrap modulo FIFO_DEPTH; the occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
REQ-015 When a push and a pop occur in the same cycle, the FIFO SHALL do both and occupancy SHALL be unchanged, including when the FIFO is full.
REQ-016 A push into a full FIFO with no simultaneous pop SHALL drop the new byte and set overflow; overflow clears only on reset.
REQ-017 rx_data SHALL be stable while rx_valid is high and rx_ready is low.
REQ-018 An idle counter SHALL count consecutive y_in=0 cycles in IDLE, saturating at IDLE_TIMEOUT; on reaching it, the have_prev flag clears.
REQ-019 The last byte seen in COMMIT SHALL be recorded as prev_byte and have_prev SHALL set, whether or not the byte was pushed.

Reset
REQ-020 While reset is high at a clock edge, the block SHALL set state=IDLE, count=0, FIFO empty, rx_valid=0, rx_data=0, overflow=0, busy=0, have_prev=0, prev_byte=0, idle counter=0.
REQ-021 Reset asserted mid-frame SHALL discard the partial frame; no push occurs for it.

Configuration
REQ-022 Macro B09_FRAME_RX_DUP_FILTER_EN SHALL select duplicate filtering:
- Defined: in COMMIT, a byte equal to prev_byte while have_prev=1 is not pushed and does not set overflow.
- Undefined: every completed frame is pushed; the comparison logic is absent.

Structure
REQ-023 A shared package b09_pkg SHALL hold the FSM state enum (IDLE, SHIFT, COMMIT), the frame data width constant (8) and the start-bit value constant.
REQ-024 The FIFO SHALL be a sub-module b09_sync_fifo (parameters WIDTH, DEPTH) instantiated once; the FSM and filter stay in b09_frame_rx.

Verification
REQ-025 Single frame: after reset, drive 1 then 0xA5 LSB first with rx_ready=1 -> rx_valid for one cycle with rx_data=0xA5, exactly 2 clocks after the last bit.
REQ-026 Back-to-back: frames 0x01, 0x80, 0xFF with no gaps and rx_ready=0 (FIFO_DEPTH=2) -> 0x01 and 0x80 buffered, 0xFF dropped, overflow=1; then rx_ready=1 -> 0x01 then 0x80 delivered.
REQ-027 Simultaneous push/pop: FIFO full at the moment a frame completes with rx_ready=1 -> no overflow, output order preserved.
REQ-028 Duplicate filter (macro defined): 0x3C, 0x3C, 0x3D -> only 0x3C and 0x3D delivered. With the macro undefined -> all three delivered.
REQ-029 Idle timeout (macro defined): 0x3C, then 16 zero cycles, then 0x3C -> 0x3C delivered twice.
REQ-030 Reset mid-frame: assert reset after 4 data bits, release it, then send 0x5A -> only 0x5A delivered, overflow=0.
